// File: rtl/pipe_pkg.sv
// Shared pipeline types: the decoded control bundle carried from ID into EX,
// plus the encodings used by the decoder's alu_op and mem_to_reg fields.
package pipe_pkg;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic [1:0] mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_LUI = 2'b10;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load currently in EX is about to write. Purely combinational.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_rt,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  output logic          haz
);

  // Register zero is hardwired, so a load targeting it never creates a dependency.
  assign haz = ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: registers decoded control and operands into EX,
// inserts a bubble on load-use hazards or flushes, and counts bubbles.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            id_reg_dst,
  input  logic            id_branch,
  input  logic            id_jump,
  input  logic            id_mem_read,
  input  logic [1:0]      id_mem_to_reg,
  input  logic            id_mem_write,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic [1:0]      id_alu_op,
  input  logic [RW-1:0]   id_rs,
  input  logic [RW-1:0]   id_rt,
  input  logic [RW-1:0]   id_rd,
  input  logic [DW-1:0]   id_rdata1,
  input  logic [DW-1:0]   id_rdata2,
  input  logic [DW-1:0]   id_imm,
  input  logic [DW-1:0]   id_pc4,
  output logic            ex_reg_dst,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_mem_read,
  output logic [1:0]      ex_mem_to_reg,
  output logic            ex_mem_write,
  output logic            ex_alu_src,
  output logic            ex_reg_write,
  output logic [1:0]      ex_alu_op,
  output logic [RW-1:0]   ex_rs,
  output logic [RW-1:0]   ex_rt,
  output logic [RW-1:0]   ex_rd,
  output logic [DW-1:0]   ex_rdata1,
  output logic [DW-1:0]   ex_rdata2,
  output logic [DW-1:0]   ex_imm,
  output logic [DW-1:0]   ex_pc4,
  output logic            stall_o,
  output logic [CNTW-1:0] bubble_cnt
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  haz;
  logic  bubble;

  assign id_ctrl = '{reg_dst:    id_reg_dst,
                     branch:     id_branch,
                     jump:       id_jump,
                     mem_read:   id_mem_read,
                     mem_to_reg: id_mem_to_reg,
                     mem_write:  id_mem_write,
                     alu_src:    id_alu_src,
                     reg_write:  id_reg_write,
                     alu_op:     id_alu_op};

  load_use_detect #(.RW(RW)) u_lud (
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .haz         (haz)
  );

  // A flushed instruction is discarded anyway, so holding it would only waste a cycle.
  assign bubble  = haz | flush_i;
  assign stall_o = haz & ~flush_i & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl   <= CTRL_NOP;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_pc4    <= '0;
    end else begin
      ex_ctrl   <= bubble ? CTRL_NOP : id_ctrl;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_rd     <= id_rd;
      ex_rdata1 <= id_rdata1;
      ex_rdata2 <= id_rdata2;
      ex_imm    <= id_imm;
      ex_pc4    <= id_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (bubble && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNTW'(1);
    end
  end

  assign ex_reg_dst    = ex_ctrl.reg_dst;
  assign ex_branch     = ex_ctrl.branch;
  assign ex_jump       = ex_ctrl.jump;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_alu_op     = ex_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference model pushes the expected EX
// state per edge, and each scenario task pops and compares after the edge.
module tb_id_ex_stage;
  import pipe_pkg::*;

  typedef struct packed {
    ctrl_t       c;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [31:0] pc4;
  } exs_t;

  typedef struct packed {
    logic        stall;
    logic        bubble;
    exs_t        ex;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  typedef struct packed {
    exs_t v;
    logic fl;
    logic rr;
  } stim_t;

  localparam ctrl_t C_RADD = ctrl_t'{1'b1, 1'b0, 1'b0, 1'b0, MTR_ALU, 1'b0, 1'b0, 1'b1, ALUOP_FUNCT};
  localparam ctrl_t C_LW   = ctrl_t'{1'b0, 1'b0, 1'b0, 1'b1, MTR_MEM, 1'b0, 1'b1, 1'b1, ALUOP_ADD};

  logic clk = 1'b0;
  logic rst, flush_i;
  logic id_reg_dst, id_branch, id_jump, id_mem_read, id_mem_write, id_alu_src, id_reg_write;
  logic [1:0] id_mem_to_reg, id_alu_op;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [31:0] id_rdata1, id_rdata2, id_imm, id_pc4;
  logic ex_reg_dst, ex_branch, ex_jump, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write;
  logic [1:0] ex_mem_to_reg, ex_alu_op;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic stall_o;
  logic [15:0] bubble_cnt;
  logic s_reg_dst, s_branch, s_jump, s_mem_read, s_mem_write, s_alu_src, s_reg_write, s_stall;
  logic [1:0] s_mem_to_reg, s_alu_op;
  logic [4:0] s_rs, s_rt, s_rd;
  logic [31:0] s_rdata1, s_rdata2, s_imm, s_pc4;
  logic [3:0] s_cnt;

  exp_t exp_q[$];
  exs_t m;
  logic [15:0] mcnt;
  logic [3:0]  mcnt4;
  logic obs_stall;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .id_reg_dst(id_reg_dst), .id_branch(id_branch), .id_jump(id_jump), .id_mem_read(id_mem_read),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
    .ex_reg_dst(ex_reg_dst), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_mem_read(ex_mem_read),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .stall_o(stall_o), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  id_ex_stage #(.CNTW(4)) u_sat (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .id_reg_dst(id_reg_dst), .id_branch(id_branch), .id_jump(id_jump), .id_mem_read(id_mem_read),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
    .ex_reg_dst(s_reg_dst), .ex_branch(s_branch), .ex_jump(s_jump), .ex_mem_read(s_mem_read),
    .ex_mem_to_reg(s_mem_to_reg), .ex_mem_write(s_mem_write), .ex_alu_src(s_alu_src),
    .ex_reg_write(s_reg_write), .ex_alu_op(s_alu_op),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2), .ex_imm(s_imm), .ex_pc4(s_pc4),
    .stall_o(s_stall), .bubble_cnt(s_cnt)
  );

  function automatic exs_t mk(input ctrl_t c, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    exs_t v;
    v.c   = c;
    v.rs  = rs;
    v.rt  = rt;
    v.rd  = rd;
    v.r1  = $urandom;
    v.r2  = $urandom;
    v.imm = $urandom;
    v.pc4 = $urandom;
    return v;
  endfunction

  function automatic exs_t rnd();
    return mk(ctrl_t'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
  endfunction

  function automatic exs_t sample();
    exs_t o;
    o.c   = '{ex_reg_dst, ex_branch, ex_jump, ex_mem_read, ex_mem_to_reg, ex_mem_write,
              ex_alu_src, ex_reg_write, ex_alu_op};
    o.rs  = ex_rs;
    o.rt  = ex_rt;
    o.rd  = ex_rd;
    o.r1  = ex_rdata1;
    o.r2  = ex_rdata2;
    o.imm = ex_imm;
    o.pc4 = ex_pc4;
    return o;
  endfunction

  // Drives one ID cycle, records the combinational stall, and pushes the model's post-edge state.
  task automatic drive(input exs_t v, input logic fl, input logic rr);
    exp_t e;
    logic haz;
    @(negedge clk);
    rst = rr; flush_i = fl;
    {id_reg_dst, id_branch, id_jump, id_mem_read, id_mem_to_reg, id_mem_write,
     id_alu_src, id_reg_write, id_alu_op} = v.c;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_rdata1 = v.r1; id_rdata2 = v.r2; id_imm = v.imm; id_pc4 = v.pc4;
    #1;
    obs_stall = stall_o;
    haz = m.c.mem_read && (m.rt != 5'd0) && ((m.rt == v.rs) || (m.rt == v.rt));
    e.stall = haz && !fl && !rr;
    e.bubble = 1'b0;
    if (rr) begin
      m = '0; mcnt = '0; mcnt4 = '0;
    end else if (haz || fl) begin
      m = v; m.c = CTRL_NOP; e.bubble = 1'b1;
      if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      if (mcnt4 != 4'hF) mcnt4 = mcnt4 + 4'd1;
    end else begin
      m = v;
    end
    e.ex = m; e.cnt = mcnt; e.cnt4 = mcnt4;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      exp_t e; exs_t o;
      drive(rnd(), 1'($urandom), 1'b1);
      e = exp_q.pop_front(); o = sample();
      vectors++; if (obs_stall !== e.stall) begin miscompares++; $display("[TB] FAIL reset stall_o got %b want %b", obs_stall, e.stall); end
      vectors++; if (o !== e.ex) begin miscompares++; $display("[TB] FAIL reset ex got %h want %h", o, e.ex); end
      vectors++; if (bubble_cnt !== e.cnt) begin miscompares++; $display("[TB] FAIL reset bubble_cnt got %0d want %0d", bubble_cnt, e.cnt); end
      vectors++; if (s_cnt !== e.cnt4) begin miscompares++; $display("[TB] FAIL reset cnt4 got %0d want %0d", s_cnt, e.cnt4); end
    end
  endtask

  task automatic test_rtype();
    stim_t s[2];
    s[0] = '{mk(C_RADD, 5'd2, 5'd3, 5'd4), 1'b0, 1'b0};
    s[1] = '{mk(C_RADD, 5'd8, 5'd9, 5'd10), 1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      exp_t e; exs_t o;
      drive(s[i].v, s[i].fl, s[i].rr);
      e = exp_q.pop_front(); o = sample();
      vectors++; if (obs_stall !== 1'b0 || obs_stall !== e.stall) begin miscompares++; $display("[TB] FAIL rtype stall_o got %b want %b", obs_stall, e.stall); end
      vectors++; if (o !== s[i].v || o !== e.ex) begin miscompares++; $display("[TB] FAIL rtype ex got %h want %h", o, e.ex); end
      vectors++; if (bubble_cnt !== e.cnt) begin miscompares++; $display("[TB] FAIL rtype bubble_cnt got %0d want %0d", bubble_cnt, e.cnt); end
    end
  endtask

  task automatic test_load_use();
    stim_t s[3];
    s[0] = '{mk(C_LW, 5'd1, 5'd5, 5'd0), 1'b0, 1'b0};
    s[1] = '{mk(C_RADD, 5'd5, 5'd6, 5'd7), 1'b0, 1'b0};
    s[2] = s[1];
    for (int i = 0; i < 3; i++) begin
      exp_t e; exs_t o;
      drive(s[i].v, s[i].fl, s[i].rr);
      e = exp_q.pop_front(); o = sample();
      vectors++; if (obs_stall !== e.stall) begin miscompares++; $display("[TB] FAIL load_use stall_o got %b want %b", obs_stall, e.stall); end
      vectors++; if (o.c !== e.ex.c) begin miscompares++; $display("[TB] FAIL load_use ctrl got %h want %h", o.c, e.ex.c); end
      if (!e.bubble) begin
        vectors++; if (o !== e.ex) begin miscompares++; $display("[TB] FAIL load_use ex got %h want %h", o, e.ex); end
      end
      vectors++; if (bubble_cnt !== e.cnt) begin miscompares++; $display("[TB] FAIL load_use bubble_cnt got %0d want %0d", bubble_cnt, e.cnt); end
      if (i == 1) begin
        vectors++; if (obs_stall !== 1'b1 || o.c !== CTRL_NOP || bubble_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL load_use_bubble stall/ctrl/cnt got %b/%h/%0d want 1/0/1", obs_stall, o.c, bubble_cnt); end
      end
      if (i == 2) begin
        vectors++; if (o.rs !== 5'd5 || o.c.reg_write !== 1'b1) begin miscompares++; $display("[TB] FAIL load_use_advance ex_rs got %0d want 5", o.rs); end
      end
    end
  endtask

  task automatic test_reg_zero();
    stim_t s[3];
    s[0] = '{rnd(), 1'b0, 1'b1};
    s[1] = '{mk(C_LW, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0};
    s[2] = '{mk(C_RADD, 5'd0, 5'd0, 5'd3), 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      exp_t e; exs_t o;
      drive(s[i].v, s[i].fl, s[i].rr);
      e = exp_q.pop_front(); o = sample();
      vectors++; if (obs_stall !== e.stall) begin miscompares++; $display("[TB] FAIL reg_zero stall_o got %b want %b", obs_stall, e.stall); end
      vectors++; if (o !== e.ex) begin miscompares++; $display("[TB] FAIL reg_zero ex got %h want %h", o, e.ex); end
      vectors++; if (bubble_cnt !== e.cnt || bubble_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL reg_zero bubble_cnt got %0d want %0d", bubble_cnt, e.cnt); end
    end
  endtask

  task automatic test_flush_wins();
    stim_t s[3];
    s[0] = '{mk(C_LW, 5'd2, 5'd7, 5'd0), 1'b0, 1'b0};
    s[1] = '{mk(C_RADD, 5'd1, 5'd7, 5'd8), 1'b1, 1'b0};
    s[2] = '{mk(C_RADD, 5'd3, 5'd4, 5'd9), 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      exp_t e; exs_t o;
      drive(s[i].v, s[i].fl, s[i].rr);
      e = exp_q.pop_front(); o = sample();
      vectors++; if (obs_stall !== e.stall) begin miscompares++; $display("[TB] FAIL flush stall_o got %b want %b", obs_stall, e.stall); end
      vectors++; if (o.c !== e.ex.c) begin miscompares++; $display("[TB] FAIL flush ctrl got %h want %h", o.c, e.ex.c); end
      if (!e.bubble) begin
        vectors++; if (o !== e.ex) begin miscompares++; $display("[TB] FAIL flush ex got %h want %h", o, e.ex); end
      end else begin
        vectors++; if ($isunknown(o)) begin miscompares++; $display("[TB] FAIL flush ex_unknown got %h want no X", o); end
      end
      vectors++; if (bubble_cnt !== e.cnt) begin miscompares++; $display("[TB] FAIL flush bubble_cnt got %0d want %0d", bubble_cnt, e.cnt); end
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t s[3];
    s[0] = '{mk(C_LW, 5'd1, 5'd9, 5'd0), 1'b0, 1'b0};
    s[1] = '{mk(C_RADD, 5'd9, 5'd2, 5'd3), 1'b0, 1'b1};
    s[2] = s[1];
    s[2].rr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_t e; exs_t o;
      drive(s[i].v, s[i].fl, s[i].rr);
      e = exp_q.pop_front(); o = sample();
      vectors++; if (obs_stall !== e.stall) begin miscompares++; $display("[TB] FAIL rst_mid stall_o got %b want %b", obs_stall, e.stall); end
      vectors++; if (o !== e.ex) begin miscompares++; $display("[TB] FAIL rst_mid ex got %h want %h", o, e.ex); end
      vectors++; if (bubble_cnt !== e.cnt) begin miscompares++; $display("[TB] FAIL rst_mid bubble_cnt got %0d want %0d", bubble_cnt, e.cnt); end
    end
  endtask

  task automatic test_saturate();
    exp_t e; exs_t o;
    drive(rnd(), 1'b0, 1'b1);
    e = exp_q.pop_front();
    for (int i = 0; i < 20; i++) begin
      drive(rnd(), 1'b1, 1'b0);
      e = exp_q.pop_front(); o = sample();
      vectors++; if (obs_stall !== 1'b0 || o.c !== CTRL_NOP) begin miscompares++; $display("[TB] FAIL saturate stall/ctrl got %b/%h want 0/0", obs_stall, o.c); end
      vectors++; if (s_cnt !== e.cnt4) begin miscompares++; $display("[TB] FAIL saturate cnt4 got %0d want %0d", s_cnt, e.cnt4); end
      vectors++; if (bubble_cnt !== e.cnt) begin miscompares++; $display("[TB] FAIL saturate bubble_cnt got %0d want %0d", bubble_cnt, e.cnt); end
    end
    vectors++; if (s_cnt !== 4'd15 || bubble_cnt !== 16'd20) begin miscompares++; $display("[TB] FAIL saturate_final cnt4/cnt got %0d/%0d want 15/20", s_cnt, bubble_cnt); end
  endtask

  initial begin
    m = '0; mcnt = '0; mcnt4 = '0;
    rst = 1'b1; flush_i = 1'b0;
    test_reset();
    test_rtype();
    test_load_use();
    test_reg_zero();
    test_flush_wins();
    test_reset_mid_stall();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
